// File: rtl/page_stream_bridge.sv
// page_stream_bridge: glue between leaf-interface user ports and an HLS kernel.
// Per-channel FIFOs bridge vld/ack streams; an FSM sequences ap_rst/ap_start.

module page_stream_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_vld,
  output logic             push_ack,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_vld,
  input  logic             pop_ack
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_nxt;
  logic                  push;
  logic                  pop;

  // push_ack is the registered not-full flag, so a full FIFO refuses a push
  // even when a pop happens on the same edge.
  assign push     = push_vld & push_ack;
  assign pop      = pop_vld & pop_ack;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      push_ack <= 1'b0;
      pop_vld  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count    <= count_nxt;
      push_ack <= (count_nxt != CNT_W'(DEPTH));
      pop_vld  <= (count_nxt != CNT_W'(0));
    end
  end

  // Storage is not reset; pop_vld alone guards against stale words.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

module page_stream_bridge #(
  parameter int unsigned PAYLOAD_BITS    = 32,
  parameter int unsigned NUM_IN_PORTS    = 1,
  parameter int unsigned NUM_OUT_PORTS   = 1,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2,
  parameter int unsigned RST_HOLD_CYCLES = 4,
  parameter int unsigned AUTO_RESTART    = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    dout_leaf_interface2user,
  input  logic [NUM_IN_PORTS-1:0]                 vld_interface2user,
  output logic [NUM_IN_PORTS-1:0]                 ack_user2interface,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    kin_data,
  output logic [NUM_IN_PORTS-1:0]                 kin_vld,
  input  logic [NUM_IN_PORTS-1:0]                 kin_ack,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   kout_data,
  input  logic [NUM_OUT_PORTS-1:0]                kout_vld,
  output logic [NUM_OUT_PORTS-1:0]                kout_ack,
  output logic                                    ap_rst,
  output logic                                    ap_start,
  input  logic                                    ap_done,
  input  logic                                    restart,
  output logic [15:0]                             done_count
);
  localparam int unsigned HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                kernel_en;
  logic [NUM_IN_PORTS-1:0]  in_vld_q;
  logic [NUM_OUT_PORTS-1:0] out_ack_q;

  // Interface -> kernel channels; kernel side is gated off while in HOLD.
  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    page_stream_fifo #(
      .WIDTH      (PAYLOAD_BITS),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_data (dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .push_vld  (vld_interface2user[i]),
      .push_ack  (ack_user2interface[i]),
      .pop_data  (kin_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .pop_vld   (in_vld_q[i]),
      .pop_ack   (kin_ack[i] & kernel_en)
    );
    assign kin_vld[i] = in_vld_q[i] & kernel_en;
  end

  // Kernel -> interface channels.
  for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
    page_stream_fifo #(
      .WIDTH      (PAYLOAD_BITS),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_data (kout_data[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .push_vld  (kout_vld[j] & kernel_en),
      .push_ack  (out_ack_q[j]),
      .pop_data  (din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .pop_vld   (vld_user2interface[j]),
      .pop_ack   (ack_interface2user[j])
    );
    assign kout_ack[j] = out_ack_q[j] & kernel_en;
  end

  // Kernel control sequencer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_HOLD;
      hold_cnt   <= '0;
      ap_rst     <= 1'b1;
      ap_start   <= 1'b0;
      kernel_en  <= 1'b0;
      done_count <= 16'd0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (hold_cnt == HOLD_W'(RST_HOLD_CYCLES - 1)) begin
            state     <= ST_START;
            ap_rst    <= 1'b0;
            ap_start  <= 1'b1;
            kernel_en <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_START: begin
          state    <= ST_RUN;
          ap_start <= 1'b0;
        end
        ST_RUN: begin
          if (ap_done) begin
            state <= ST_DONE;
            if (done_count != 16'hFFFF) done_count <= done_count + 16'd1;
          end
        end
        ST_DONE: begin
          if (AUTO_RESTART != 0) begin
            state    <= ST_START;
            ap_start <= 1'b1;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (restart) begin
            state    <= ST_START;
            ap_start <= 1'b1;
          end
        end
        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end
endmodule
